// File: rtl/uart_pkg.sv
// Shared encodings for the UART loopback FIFO: character transform modes,
// transmit handshake states and the busy-guard length.
package uart_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_SWAP = 2'd1,
        MODE_DROP = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } tx_state_e;

    // Cycles BUSY tolerates a transmitter that never drops ready.
    localparam int unsigned BUSY_GUARD = 4;
    localparam int unsigned GUARD_W    = 3;

endpackage

// File: rtl/uart_loopback_fifo_fifo.sv
// Circular character buffer with extra-MSB pointers, flush, and a registered
// fill level that tracks the pointers cycle for cycle.
module uart_byte_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0] level_q, level_d;
    logic                rd_ok_s, wr_ok_s;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign rd_data = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign level   = level_q;

    // Accept/pop qualification and next pointer values; a read frees a slot for a same-cycle write.
    always_comb begin
        rd_ok_s  = rd_en && !empty;
        wr_ok_s  = wr_en && (!full || rd_ok_s);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = {(DEPTH_LOG2+1){1'b0}};
            rd_ptr_d = {(DEPTH_LOG2+1){1'b0}};
        end else begin
            if (wr_ok_s) begin
                wr_ptr_d = wr_ptr_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_ok_s) begin
                rd_ptr_d = rd_ptr_q + {{DEPTH_LOG2{1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
        level_d = wr_ptr_d - rd_ptr_d;
    end

    // Pointer and level registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= {(DEPTH_LOG2+1){1'b0}};
            rd_ptr_q <= {(DEPTH_LOG2+1){1'b0}};
            level_q  <= {(DEPTH_LOG2+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are only meaningful between the pointers, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_ok_s && !flush) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_loopback_fifo.sv
// UART echo path: edge-captures received characters, transforms and buffers
// them, and hands them to the transmitter with a request/ready handshake.
module uart_loopback_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rx_valid,
    input  logic [DATA_W-1:0]     rx_data,
    input  logic                  rx_error,
    input  logic                  tx_ready,
    output logic                  tx_transfer,
    output logic [DATA_W-1:0]     tx_data,
    input  logic [1:0]            mode,
    input  logic                  flush,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow,
    output logic [ERR_CNT_W-1:0]  err_count,
    input  logic                  clr_status
);

    import uart_pkg::*;

    localparam logic [DATA_W-1:0]    CASE_BIT = DATA_W'(32'd1) << 5;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = {ERR_CNT_W{1'b1}};

    logic                 rx_valid_q, rx_error_q, cap_valid_q;
    logic [DATA_W-1:0]    cap_data_q;
    logic                 rx_edge_s, err_edge_s, ovf_evt_s;
    logic                 wr_en_s, rd_en_s, full_s, empty_s;
    logic [DATA_W-1:0]    wr_data_s, rd_data_s;
    mode_e                mode_s;
    tx_state_e            state_q, state_d;
    logic [GUARD_W-1:0]   guard_q, guard_d;
    logic                 tx_transfer_q, tx_transfer_d;
    logic [DATA_W-1:0]    tx_data_q, tx_data_d;
    logic                 overflow_q, overflow_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    function automatic logic [DATA_W-1:0] case_swap(input logic [DATA_W-1:0] d);
        logic is_upper, is_lower;
        is_upper = (d >= DATA_W'(7'h41)) && (d <= DATA_W'(7'h5A));
        is_lower = (d >= DATA_W'(7'h61)) && (d <= DATA_W'(7'h7A));
        return (is_upper || is_lower) ? (d ^ CASE_BIT) : d;
    endfunction

    assign mode_s     = mode_e'(mode);
    assign rx_edge_s  = rx_valid && !rx_valid_q && !rx_error;
    assign err_edge_s = rx_error && !rx_error_q;

    // Edge-detect history and the one-deep capture stage feeding the FIFO write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_valid_q  <= 1'b0;
            rx_error_q  <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_data_q  <= {DATA_W{1'b0}};
        end else begin
            rx_valid_q  <= rx_valid;
            rx_error_q  <= rx_error;
            cap_valid_q <= rx_edge_s;
            if (rx_edge_s) begin
                cap_data_q <= rx_data;
            end
        end
    end

    // Write-time transform; the mode is sampled when the captured character is written.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_data_s = cap_data_q;
        case (mode_s)
            MODE_PASS: wr_en_s = cap_valid_q;
            MODE_SWAP: begin
                wr_en_s   = cap_valid_q;
                wr_data_s = case_swap(cap_data_q);
            end
            MODE_DROP: wr_en_s = 1'b0;
            MODE_RSVD: wr_en_s = cap_valid_q;
            default:   wr_en_s = cap_valid_q;
        endcase
    end

    uart_byte_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en_s),
        .wr_data (wr_data_s),
        .rd_en   (rd_en_s),
        .rd_data (rd_data_s),
        .flush   (flush),
        .full    (full_s),
        .empty   (empty_s),
        .level   (fifo_level)
    );

    // Transmit handshake next-state; a pop is suppressed during flush so flush wins.
    always_comb begin
        state_d       = state_q;
        guard_d       = guard_q;
        tx_transfer_d = 1'b0;
        tx_data_d     = tx_data_q;
        rd_en_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_s && tx_ready && !flush) begin
                    rd_en_s       = 1'b1;
                    tx_transfer_d = 1'b1;
                    tx_data_d     = rd_data_s;
                    guard_d       = {GUARD_W{1'b0}};
                    state_d       = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!tx_ready) begin
                    state_d = DRAIN;
                end else if (guard_q == GUARD_W'(BUSY_GUARD - 1)) begin
                    state_d = DRAIN;
                end else begin
                    guard_d = guard_q + GUARD_W'(1);
                end
            end
            DRAIN: begin
                if (tx_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A write is lost to a full FIFO only when no same-cycle pop frees a slot.
    assign ovf_evt_s = wr_en_s && full_s && !rd_en_s && !flush;

    // Sticky status next-state; a clear overrides any event in the same cycle.
    always_comb begin
        overflow_d  = overflow_q;
        err_count_d = err_count_q;
        if (clr_status) begin
            overflow_d  = 1'b0;
            err_count_d = {ERR_CNT_W{1'b0}};
        end else begin
            if (ovf_evt_s) begin
                overflow_d = 1'b1;
            end else begin
                overflow_d = overflow_q;
            end
            if (err_edge_s && (err_count_q != ERR_MAX)) begin
                err_count_d = err_count_q + ERR_CNT_W'(1);
            end else begin
                err_count_d = err_count_q;
            end
        end
    end

    // FSM, transmit outputs and status registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            guard_q       <= {GUARD_W{1'b0}};
            tx_transfer_q <= 1'b0;
            tx_data_q     <= {DATA_W{1'b0}};
            overflow_q    <= 1'b0;
            err_count_q   <= {ERR_CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            guard_q       <= guard_d;
            tx_transfer_q <= tx_transfer_d;
            tx_data_q     <= tx_data_d;
            overflow_q    <= overflow_d;
            err_count_q   <= err_count_d;
        end
    end

    assign tx_transfer = tx_transfer_q;
    assign tx_data     = tx_data_q;
    assign overflow    = overflow_q;
    assign err_count   = err_count_q;

endmodule
